// File: rtl/fifo_prog_pkg.sv
// Shared constants and sizing helper for the programmable-threshold FIFO.
package fifo_prog_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 16;

  // Level counter must hold 0..Depth inclusive, hence one extra bit.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_prog_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_prog_mem #(
  parameter int DataWidth = 8,
  parameter int Depth     = 16,
  parameter int AddrWidth = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [DataWidth-1:0] wdata,
  input  logic [AddrWidth-1:0] raddr,
  output logic [DataWidth-1:0] rdata
);

  logic [DataWidth-1:0] mem_r [Depth];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/fifo_prog.sv
// Synchronous FIFO with runtime almost-full/almost-empty thresholds and flush.
// Define FIFO_OUTREG_EN to add a registered output stage (2-cycle write-to-rvalid).
module fifo_prog
  import fifo_prog_pkg::*;
#(
  parameter int  DataWidth  = DEFAULT_DATA_WIDTH,
  parameter int  Depth      = DEFAULT_DEPTH,
  localparam int CountWidth = count_width(Depth)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  input  logic [DataWidth-1:0]  data_i,
  input  logic                  rready_i,
  output logic                  rvalid_o,
  output logic [DataWidth-1:0]  data_o,
  input  logic                  flush_i,
  input  logic [CountWidth-1:0] afull_thr_i,
  input  logic [CountWidth-1:0] aempty_thr_i,
  output logic [CountWidth-1:0] level_o,
  output logic                  is_full_o,
  output logic                  is_empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o
);

  localparam int AddrWidth = $clog2(Depth);
  localparam logic [CountWidth-1:0] DepthCount = CountWidth'(Depth);
  localparam logic [CountWidth-1:0] OneCount   = CountWidth'(1);
  localparam logic [CountWidth-1:0] ZeroCount  = CountWidth'(0);

  if (DataWidth < 1 || Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_param
    $error("fifo_prog: DataWidth must be >= 1 and Depth a power of two >= 2");
  end

  logic [CountWidth-1:0] level_r;
  logic [AddrWidth-1:0]  wr_ptr_r;
  logic [AddrWidth-1:0]  rd_ptr_r;
  logic [DataWidth-1:0]  mem_rdata_s;
  logic                  wr_fire_s;
  logic                  rd_fire_s;
  logic                  mem_pop_s;

  assign is_full_o      = (level_r == DepthCount);
  assign is_empty_o     = (level_r == ZeroCount);
  assign almost_full_o  = (level_r >= afull_thr_i);
  assign almost_empty_o = (level_r <= aempty_thr_i);
  assign level_o        = level_r;

  // No pass-through when full: a same-cycle read never frees a slot for the write.
  assign wready_o  = reset_i & ~flush_i & ~is_full_o;
  assign wr_fire_s = wvalid_i & wready_o;
  assign rd_fire_s = rvalid_o & rready_i;

`ifdef FIFO_OUTREG_EN
  logic                  out_valid_r;
  logic [DataWidth-1:0]  out_data_r;
  logic [CountWidth-1:0] mem_count_s;

  // The output-stage word is part of level_r, so the array holds the remainder.
  assign mem_count_s = level_r - {{(CountWidth-1){1'b0}}, out_valid_r};
  assign mem_pop_s   = (mem_count_s != ZeroCount) && (!out_valid_r || rd_fire_s) && !flush_i;
  assign rvalid_o    = out_valid_r & ~flush_i;
  assign data_o      = out_data_r;

  // Output stage: refill from the array whenever it is empty or being drained
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DataWidth{1'b0}};
    end else if (flush_i) begin
      out_valid_r <= 1'b0;
    end else if (mem_pop_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= mem_rdata_s;
    end else if (rd_fire_s) begin
      out_valid_r <= 1'b0;
    end
  end
`else
  assign mem_pop_s = rd_fire_s;
  assign rvalid_o  = ~is_empty_o & ~flush_i;
  assign data_o    = rvalid_o ? mem_rdata_s : {DataWidth{1'b0}};
`endif

  // Pointers and occupancy; flush overrides both handshakes
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      level_r  <= ZeroCount;
      wr_ptr_r <= {AddrWidth{1'b0}};
      rd_ptr_r <= {AddrWidth{1'b0}};
    end else if (flush_i) begin
      level_r  <= ZeroCount;
      wr_ptr_r <= {AddrWidth{1'b0}};
      rd_ptr_r <= {AddrWidth{1'b0}};
    end else begin
      if (wr_fire_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AddrWidth-1){1'b0}}, 1'b1};
      end
      if (mem_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AddrWidth-1){1'b0}}, 1'b1};
      end
      case ({wr_fire_s, rd_fire_s})
        2'b10:   level_r <= level_r + OneCount;
        2'b01:   level_r <= level_r - OneCount;
        default: level_r <= level_r;
      endcase
    end
  end

  fifo_prog_mem #(
    .DataWidth (DataWidth),
    .Depth     (Depth),
    .AddrWidth (AddrWidth)
  ) u_mem (
    .clk   (clk_i),
    .we    (wr_fire_s),
    .waddr (wr_ptr_r),
    .wdata (data_i),
    .raddr (rd_ptr_r),
    .rdata (mem_rdata_s)
  );

endmodule

// File: tb/tb_fifo_prog.sv
// Directed self-checking bench for fifo_prog (DataWidth=8, Depth=16).
module tb_fifo_prog;

  localparam int DW = 8;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          wvalid;
  logic          wready;
  logic [DW-1:0] data_in;
  logic          rready;
  logic          rvalid;
  logic [DW-1:0] data_out;
  logic          flush;
  logic [CW-1:0] afull_thr;
  logic [CW-1:0] aempty_thr;
  logic [CW-1:0] level;
  logic          is_full;
  logic          is_empty;
  logic          almost_full;
  logic          almost_empty;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fifo_prog #(.DataWidth(8), .Depth(16)) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .wvalid_i       (wvalid),
    .wready_o       (wready),
    .data_i         (data_in),
    .rready_i       (rready),
    .rvalid_o       (rvalid),
    .data_o         (data_out),
    .flush_i        (flush),
    .afull_thr_i    (afull_thr),
    .aempty_thr_i   (aempty_thr),
    .level_o        (level),
    .is_full_o      (is_full),
    .is_empty_o     (is_empty),
    .almost_full_o  (almost_full),
    .almost_empty_o (almost_empty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
    wvalid  = w;
    data_in = d;
    rready  = r;
    flush   = f;
    @(posedge clk);
    #1;
    wvalid = 1'b0;
    rready = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_level"},  32'(level),        32'd0);
    check({tag, "_rvalid"}, 32'(rvalid),       32'd0);
    check({tag, "_wready"}, 32'(wready),       32'd0);
    check({tag, "_empty"},  32'(is_empty),     32'd1);
    check({tag, "_full"},   32'(is_full),      32'd0);
    check({tag, "_afull"},  32'(almost_full),  32'd0);
    check({tag, "_aempty"}, 32'(almost_empty), 32'd1);
    check({tag, "_data"},   32'(data_out),     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_i    = 1'b0;
    wvalid     = 1'b0;
    data_in    = 8'h00;
    rready     = 1'b0;
    flush      = 1'b0;
    afull_thr  = 5'd12;
    aempty_thr = 5'd3;

    // Reset state
    #2;
    check_reset_values("rst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_i = 1'b1;
    #1;
    check("rst_rel_wready", 32'(wready), 32'd1);
    check("rst_rel_empty",  32'(is_empty), 32'd1);

    // Write 1..5, read back in order
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 8'(k + 1), 1'b0, 1'b0);
      check("w5_level", 32'(level), 32'(k + 1));
      check("w5_rvalid", 32'(rvalid), 32'd1);
    end
    for (int k = 0; k < 5; k++) begin
      check("r5_data", 32'(data_out), 32'(k + 1));
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("r5_level", 32'(level), 32'(4 - k));
    end
    check("r5_empty",  32'(is_empty), 32'd1);
    check("r5_rvalid", 32'(rvalid),   32'd0);

    // Fill to 16 tracking thresholds, then hold 0xAA against a full FIFO
    for (int k = 0; k < 16; k++) begin
      check("fill_aempty", 32'(almost_empty), 32'(k <= 3));
      check("fill_afull",  32'(almost_full),  32'(k >= 12));
      step(1'b1, 8'(8'h10 + k), 1'b0, 1'b0);
    end
    check("full_level",  32'(level),        32'd16);
    check("full_flag",   32'(is_full),      32'd1);
    check("full_wready", 32'(wready),       32'd0);
    check("full_afull",  32'(almost_full),  32'd1);
    check("full_aempty", 32'(almost_empty), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 8'hAA, 1'b0, 1'b0);
      check("full_hold_level", 32'(level), 32'd16);
    end
    check("full_rw_data", 32'(data_out), 32'h10);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    check("full_rw_level", 32'(level), 32'd15);
    for (int k = 1; k < 16; k++) begin
      check("full_drain_data", 32'(data_out), 32'(8'h10 + k));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("full_drain_empty", 32'(is_empty), 32'd1);

    // Level 8 steady-state streaming with pointer wrap
    for (int k = 0; k < 8; k++) step(1'b1, 8'(8'h40 + k), 1'b0, 1'b0);
    check("stream_start_level", 32'(level), 32'd8);
    for (int k = 0; k < 20; k++) begin
      check("stream_data", 32'(data_out), 32'(8'h40 + k));
      step(1'b1, 8'(8'h48 + k), 1'b1, 1'b0);
      check("stream_level", 32'(level), 32'd8);
    end
    for (int k = 0; k < 8; k++) begin
      check("stream_tail_data", 32'(data_out), 32'(8'h54 + k));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("stream_end_empty", 32'(is_empty), 32'd1);

    // Flush at level 10 with both handshakes offered
    for (int k = 0; k < 10; k++) step(1'b1, 8'(8'h60 + k), 1'b0, 1'b0);
    check("flush_pre_level", 32'(level), 32'd10);
    wvalid  = 1'b1;
    data_in = 8'hEE;
    rready  = 1'b1;
    flush   = 1'b1;
    #1;
    check("flush_wready", 32'(wready), 32'd0);
    check("flush_rvalid", 32'(rvalid), 32'd0);
    @(posedge clk); #1;
    wvalid = 1'b0;
    rready = 1'b0;
    flush  = 1'b0;
    check("flush_level",  32'(level),    32'd0);
    check("flush_empty",  32'(is_empty), 32'd1);
    check("flush_rvalid2", 32'(rvalid),  32'd0);
    step(1'b1, 8'h77, 1'b0, 1'b0);
    check("post_flush_level", 32'(level),    32'd1);
    check("post_flush_data",  32'(data_out), 32'h77);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_flush_empty", 32'(is_empty), 32'd1);

    // Asynchronous reset pulse at level 7
    for (int k = 0; k < 7; k++) step(1'b1, 8'(8'h30 + k), 1'b0, 1'b0);
    check("mid_rst_pre_level", 32'(level), 32'd7);
    reset_i = 1'b0;
    #1;
    check_reset_values("mid_rst");
    @(posedge clk); #1;
    reset_i = 1'b1;
    #1;
    check("mid_rst_rel_wready", 32'(wready), 32'd1);
    step(1'b1, 8'h5A, 1'b0, 1'b0);
`ifdef FIFO_OUTREG_EN
    check("after_rst_rvalid_lat1", 32'(rvalid), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
`endif
    check("after_rst_rvalid", 32'(rvalid),   32'd1);
    check("after_rst_data",   32'(data_out), 32'h5A);
    check("after_rst_level",  32'(level),    32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("after_rst_empty",  32'(is_empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_prog.md
FIFO_PROG -- requirements
Module: fifo_prog

Interface
REQ-001 Parameter DataWidth, default 8, word width in bits, SHALL be at least 1.
REQ-002 Parameter Depth, default 16, storage capacity in words, SHALL be a power of two and at least 2; elaboration SHALL fail otherwise.
REQ-003 Derived constant CountWidth SHALL equal $clog2(Depth)+1.
REQ-004 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_i  input  1  reset, asynchronous assert, active-low.
REQ-006 wvalid_i  input  1  producer offers data_i.
REQ-007 wready_o  output  1  FIFO can accept a word.
REQ-008 data_i  input  DataWidth  write data.
REQ-009 rready_i  input  1  consumer can take data_o.
REQ-010 rvalid_o  output  1  data_o holds the oldest word.
REQ-011 data_o  output  DataWidth  head-of-queue data.
REQ-012 flush_i  input  1  synchronous discard of all contents.
REQ-013 afull_thr_i, aempty_thr_i  input  CountWidth  runtime almost-full / almost-empty thresholds.
REQ-014 level_o  output  CountWidth  number of stored words, 0..Depth.
REQ-015 is_full_o, is_empty_o, almost_full_o, almost_empty_o  output  1  status flags.

Function
REQ-016 Write handshake: word accepted on a rising edge where wvalid_i && wready_o; wready_o SHALL equal !is_full_o.
REQ-017 Read handshake: word consumed on a rising edge where rvalid_o && rready_i; data_o SHALL stay stable while rvalid_o && !rready_i.
REQ-018 Words SHALL leave in acceptance order, with no loss or duplication.
REQ-019 Write-to-rvalid latency SHALL be 1 cycle (word accepted at edge N is visible at edge N+1) when FIFO_OUTREG_EN is undefined.
REQ-020 Simultaneous accepted read and write SHALL leave level_o unchanged.
REQ-021 When full, writes SHALL be refused even if a read occurs the same cycle (no pass-through); when empty, no read is possible (rvalid_o=0).
REQ-022 Read and write pointers SHALL wrap from Depth-1 to 0 without gaps.
REQ-023 is_full_o = (level_o == Depth); is_empty_o = (level_o == 0); all four flags registered or derived from registered level only.
REQ-024 almost_full_o = (level_o >= afull_thr_i); almost_empty_o = (level_o <= aempty_thr_i); comparison unsigned at CountWidth, thresholds sampled every cycle.
REQ-025 flush_i high at edge N SHALL empty the FIFO after edge N, overriding any read or write handshake in that cycle (the write word is dropped, the read is not counted).
REQ-026 During flush_i, wready_o and rvalid_o SHALL be 0.

Reset
REQ-027 While reset_i=0: level_o=0, pointers=0, rvalid_o=0, wready_o=1 (after reset release), is_empty_o=1, is_full_o=0, almost_full_o=0, almost_empty_o=1, data_o=0.
REQ-028 Reset asserted mid-transfer SHALL discard all contents immediately; storage array contents need not be cleared.
REQ-029 wready_o SHALL be 0 while reset_i=0.

Configuration
REQ-030 Macro FIFO_OUTREG_EN, when defined, SHALL add a registered output stage driving rvalid_o/data_o; write-to-rvalid latency becomes 2 cycles, full throughput (1 word/cycle) is kept, and the output-stage word counts in level_o with total capacity still Depth.
REQ-031 Without FIFO_OUTREG_EN, data_o SHALL be read combinationally from storage at the read pointer.

Structure
REQ-032 Package fifo_prog_pkg SHALL hold the CountWidth helper function and the default DataWidth/Depth constants.
REQ-033 Storage SHALL be a sub-module fifo_prog_mem (one write port, one asynchronous read port, no reset).

Verification (DataWidth=8, Depth=16)
REQ-034 Write 0x01..0x05, then read 5 with rready_i=1 -> data_o 0x01..0x05 in order, level_o 5 -> 0, is_empty_o=1 at end.
REQ-035 Write 16 words, hold wvalid_i with 0xAA -> wready_o=0, is_full_o=1, level_o=16, 0xAA never read out.
REQ-036 afull_thr_i=12, aempty_thr_i=3; fill 0->16 -> almost_empty_o high for level 0..3, almost_full_o high for level 12..16.
REQ-037 Level 8, wvalid_i=rready_i=1 for 20 cycles -> level_o stays 8, pointers wrap, output order continuous.
REQ-038 Level 10, flush_i with wvalid_i=rready_i=1 -> level_o=0 next cycle, flushed and same-cycle write words never appear.
REQ-039 reset_i=0 pulse at level 7 -> all outputs at reset values; next write 0x5A reads back as 0x5A after 1 cycle (2 with FIFO_OUTREG_EN).
